// File: rtl/rst_seq_mon.sv
// rst_seq_mon: staggered per-domain reset sequencer with run monitor.
// Halts every domain on a channel error or when the cycle budget runs out.
module rst_seq_mon #(
   parameter int unsigned NCH        = 4,
   parameter int unsigned RST_CYCLES = 2,
   parameter int unsigned STAGGER    = 1,
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned MAX_CYCLES = 100000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NCH-1:0]   err,
   input  logic             clr,
   output logic [NCH-1:0]   sys_rst,
   output logic             run,
   output logic             halt,
   output logic             timeout,
   output logic [NCH-1:0]   err_seen,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int unsigned REL_MAX = (NCH - 1) * STAGGER;
   localparam bit          DIRECT  = (REL_MAX == 0);
   localparam int unsigned HW      = $clog2(RST_CYCLES + 1);
   localparam int unsigned RW      = (REL_MAX < 1) ? 1 : $clog2(REL_MAX + 1);

   typedef enum logic [1:0] {
      S_HOLD,
      S_REL,
      S_RUN,
      S_HALT
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       sync_q;
   logic             rst_sync;
   logic [HW-1:0]    hold_q, hold_d;
   logic [RW-1:0]    rel_q, rel_d;
   logic [NCH-1:0]   sys_q, sys_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             to_q, to_d;
   logic [NCH-1:0]   es_q, es_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], 1'b1};
      end
   end

   assign rst_sync = sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_HOLD;
         hold_q  <= '0;
         rel_q   <= '0;
         sys_q   <= '1;
         cnt_q   <= '0;
         to_q    <= 1'b0;
         es_q    <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         rel_q   <= rel_d;
         sys_q   <= sys_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
         es_q    <= es_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      rel_d   = rel_q;
      sys_d   = sys_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      es_d    = es_q;
      unique case (state_q)
         S_HOLD: begin
            sys_d = '1;
            if (rst_sync) begin
               hold_d = hold_q + HW'(1);
               if (hold_d == HW'(RST_CYCLES)) begin
                  rel_d = '0;
                  if (DIRECT) begin
                     sys_d   = '0;
                     state_d = S_RUN;
                  end else begin
                     sys_d[0] = 1'b0;
                     state_d  = S_REL;
                  end
               end
            end
         end
         S_REL: begin
            rel_d = rel_q + RW'(1);
            for (int i = 1; i < int'(NCH); i++) begin
               if (rel_d == RW'(i * STAGGER)) sys_d[i] = 1'b0;
            end
            if (rel_d == RW'(REL_MAX)) state_d = S_RUN;
         end
         S_RUN: begin
            // counter advances even on the halting edge
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            if (err != '0) begin
               es_d    = es_q | err;
               state_d = S_HALT;
            end
            if (MAX_CYCLES != 0 && cnt_d == CNT_W'(MAX_CYCLES)) begin
               to_d    = 1'b1;
               state_d = S_HALT;
            end
            if (state_d == S_HALT) sys_d = '1;
         end
         S_HALT: begin
            sys_d = '1;
            if (clr) begin
               to_d    = 1'b0;
               es_d    = '0;
               cnt_d   = '0;
               hold_d  = '0;
               rel_d   = '0;
               state_d = S_HOLD;
            end
         end
         default: state_d = S_HOLD;
      endcase
   end

   assign sys_rst     = sys_q;
   assign run         = (state_q == S_RUN);
   assign halt        = (state_q == S_HALT);
   assign timeout     = to_q;
   assign err_seen    = es_q;
   assign cycle_count = cnt_q;

endmodule
